// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants, step type and quadrature helpers for ip_encoder_mc
// Contents: register byte offsets within a channel window, channel stride,
//           CTRL/STAT bit indices, step_e decode result, phase/step helpers.
package enc_pkg;

    localparam int CH_STRIDE = 'h10;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_POS  = 4'h4;
    localparam logic [3:0] OFF_DIV  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_INV = 2;

    localparam int STAT_DIR = 0;
    localparam int STAT_ERR = 1;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Position of an {A,B} state along the forward cycle 00->10->11->01.
    function automatic logic [1:0] quad_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // A phase distance of 2 means both phases moved at once: illegal.
    function automatic step_e quad_step(input logic [1:0] prev_ab, input logic [1:0] curr_ab);
        logic [1:0] delta;
        delta = quad_phase(curr_ab) - quad_phase(prev_ab);
        case (delta)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_FWD;
            2'd3:    return STEP_REV;
            default: return STEP_ERR;
        endcase
    endfunction

endpackage

// File: rtl/enc_channel.sv
// rtl/enc_channel.sv - one encoder channel: synchroniser, glitch filter, x4 decoder, position/divider counters
// Ports: clock, reset (async, active-high); enc_a/enc_b raw phases; en/inv/div control;
//        clr, div_wr, err_clr single-cycle strobes from the register file;
//        pos (signed count), dir, err (sticky), trig (one-cycle divided pulse).
module enc_channel
    import enc_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int FILTER_LEN = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 en,
    input  logic                 inv,
    input  logic                 clr,
    input  logic [31:0]          div,
    input  logic                 div_wr,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] pos,
    output logic                 dir,
    output logic                 err,
    output logic                 trig
);

    logic [1:0]  sync1, sync2;
    logic [1:0]  cand;
    logic [3:0]  run, run_next;
    logic [1:0]  filt, prev;
    logic [31:0] dcnt;
    step_e       step, step_eff;

    // Length of the current run of identical synchronised samples, saturating.
    always_comb begin
        run_next = 4'd1;
        if (sync2 == cand) begin
            run_next = (run == 4'hF) ? run : run + 4'd1;
        end
    end

    assign step = quad_step(prev, filt);

    always_comb begin
        step_eff = step;
        if (inv && step == STEP_FWD) begin
            step_eff = STEP_REV;
        end else if (inv && step == STEP_REV) begin
            step_eff = STEP_FWD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            cand  <= 2'b00;
            run   <= 4'd0;
            filt  <= 2'b00;
            prev  <= 2'b00;
            pos   <= '0;
            dcnt  <= 32'd0;
            dir   <= 1'b0;
            err   <= 1'b0;
            trig  <= 1'b0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            cand  <= sync2;
            run   <= run_next;
            if (run_next >= 4'(FILTER_LEN)) begin
                filt <= sync2;
            end
            // prev keeps tracking even when disabled so re-enabling does not see a stale jump
            prev <= filt;
            trig <= 1'b0;

            // A new error in the same cycle as a clear request keeps the flag set.
            if (step == STEP_ERR) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            if (clr) begin
                pos  <= '0;
                dcnt <= 32'd0;
            end else begin
                if (en && step_eff == STEP_FWD) begin
                    pos <= pos + CNT_WIDTH'(1);
                    dir <= 1'b1;
                    if (div != 32'd0) begin
                        if (dcnt == div - 32'd1) begin
                            dcnt <= 32'd0;
                            trig <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 32'd1;
                        end
                    end
                end else if (en && step_eff == STEP_REV) begin
                    pos <= pos - CNT_WIDTH'(1);
                    dir <= 1'b0;
                end
                if (div_wr) begin
                    dcnt <= 32'd0;
                end
            end
        end
    end

endmodule

// File: rtl/ip_encoder_mc.sv
// rtl/ip_encoder_mc.sv - multi-channel quadrature encoder interface with AXI4-Lite register file
// Ports: clock, reset (async, active-high); s_axi_* AXI4-Lite slave (aw/w/b/ar/r);
//        enc_a/enc_b raw encoder phases per channel; trig_o per-channel divided trigger.
module ip_encoder_mc
    import enc_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int FILTER_LEN = 4,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [NUM_CH-1:0]     enc_a,
    input  logic [NUM_CH-1:0]     enc_b,
    output logic [NUM_CH-1:0]     trig_o
);

    localparam int OFF_BITS = $clog2(CH_STRIDE);
    localparam int CH_BITS  = ADDR_WIDTH - OFF_BITS;

    logic [NUM_CH-1:0]    en_r, inv_r;
    logic [31:0]          div_r [NUM_CH];
    logic [NUM_CH-1:0]    clr_p, div_wr_p, err_clr_p;
    logic [CNT_WIDTH-1:0] pos_w [NUM_CH];
    logic [31:0]          pos_ext [NUM_CH];
    logic [NUM_CH-1:0]    dir_w, err_w;

    logic [CH_BITS-1:0]  aw_ch, ar_ch;
    logic [OFF_BITS-1:0] aw_off, ar_off;
    logic                wr_fire, rd_fire;
    logic [31:0]         rd_word;

    assign aw_ch   = s_axi_awaddr[ADDR_WIDTH-1:OFF_BITS];
    assign ar_ch   = s_axi_araddr[ADDR_WIDTH-1:OFF_BITS];
    assign aw_off  = {s_axi_awaddr[OFF_BITS-1:2], 2'b00};
    assign ar_off  = {s_axi_araddr[OFF_BITS-1:2], 2'b00};
    assign wr_fire = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = s_axi_arready & s_axi_arvalid;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'd0;
        end else begin
            // Ready is a one-cycle pulse; the !ready term stops a second accept on the handshake edge.
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            if (s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready) begin
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            s_axi_arready <= 1'b0;
            if (s_axi_arvalid && !s_axi_rvalid && !s_axi_arready) begin
                s_axi_arready <= 1'b1;
            end
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_r  <= '0;
            inv_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_r[i] <= 32'd0;
            end
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (aw_ch == CH_BITS'(i)) begin
                    if (aw_off == OFF_CTRL && s_axi_wstrb[0]) begin
                        en_r[i]  <= s_axi_wdata[CTRL_EN];
                        inv_r[i] <= s_axi_wdata[CTRL_INV];
                    end
                    if (aw_off == OFF_DIV) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s_axi_wstrb[b]) begin
                                div_r[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Strobes into the channels land on the same edge as the register write.
    always_comb begin
        clr_p     = '0;
        div_wr_p  = '0;
        err_clr_p = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_fire && aw_ch == CH_BITS'(i)) begin
                if (aw_off == OFF_CTRL && s_axi_wstrb[0] && s_axi_wdata[CTRL_CLR]) begin
                    clr_p[i] = 1'b1;
                end
                if (aw_off == OFF_DIV && (|s_axi_wstrb)) begin
                    div_wr_p[i] = 1'b1;
                end
                if (aw_off == OFF_STAT && s_axi_wstrb[0] && s_axi_wdata[STAT_ERR]) begin
                    err_clr_p[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_word = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ar_ch == CH_BITS'(i)) begin
                case (ar_off)
                    OFF_CTRL: rd_word = {29'd0, inv_r[i], 1'b0, en_r[i]};
                    OFF_POS:  rd_word = pos_ext[i];
                    OFF_DIV:  rd_word = div_r[i];
                    default:  rd_word = {30'd0, err_w[i], dir_w[i]};
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        enc_channel #(
            .CNT_WIDTH  (CNT_WIDTH),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .enc_a   (enc_a[g]),
            .enc_b   (enc_b[g]),
            .en      (en_r[g]),
            .inv     (inv_r[g]),
            .clr     (clr_p[g]),
            .div     (div_r[g]),
            .div_wr  (div_wr_p[g]),
            .err_clr (err_clr_p[g]),
            .pos     (pos_w[g]),
            .dir     (dir_w[g]),
            .err     (err_w[g]),
            .trig    (trig_o[g])
        );
        assign pos_ext[g] = 32'(signed'(pos_w[g]));
    end

endmodule

// File: tb/tb_ip_encoder_mc.sv
// tb/tb_ip_encoder_mc.sv - self-checking bench for ip_encoder_mc
module tb_ip_encoder_mc;

    localparam int NUM_CH     = 4;
    localparam int CNT_WIDTH  = 32;
    localparam int FILTER_LEN = 4;
    localparam int ADDR_WIDTH = 7;
    localparam int LAT        = 2 + FILTER_LEN + 1;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [ADDR_WIDTH-1:0] s_axi_awaddr = '0;
    logic [2:0]            s_axi_awprot = 3'd0;
    logic                  s_axi_awvalid = 1'b0;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata = 32'd0;
    logic [3:0]            s_axi_wstrb = 4'd0;
    logic                  s_axi_wvalid = 1'b0;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready = 1'b0;
    logic [ADDR_WIDTH-1:0] s_axi_araddr = '0;
    logic [2:0]            s_axi_arprot = 3'd0;
    logic                  s_axi_arvalid = 1'b0;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready = 1'b0;
    logic [NUM_CH-1:0]     enc_a = '0;
    logic [NUM_CH-1:0]     enc_b = '0;
    logic [NUM_CH-1:0]     trig_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_change = 0;
    int idx [NUM_CH];
    int model_pos [NUM_CH];
    int trig_seen [$];
    int trig_wide = 0;
    logic trig1_prev = 1'b0;

    ip_encoder_mc #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .FILTER_LEN(FILTER_LEN), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .enc_a(enc_a), .enc_b(enc_b), .trig_o(trig_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (trig_o[1]) trig_seen.push_back(cyc);
        if (trig_o[1] && trig1_prev) trig_wide <= trig_wide + 1;
        trig1_prev <= trig_o[1];
    end

    function automatic logic [ADDR_WIDTH-1:0] ra(input int ch, input int off);
        return ADDR_WIDTH'(ch * 16 + off);
    endfunction

    task automatic axi_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clock);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge clock); n++; end
        if (!s_axi_awready) begin
            checks++; failures++;
            $display("FAIL write_awready_timeout addr=%h got=0 want=1", addr);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
            return;
        end
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            failures++;
            $display("FAIL write_bresp addr=%h got bvalid=%b bresp=%b want 1/00", addr, s_axi_bvalid, s_axi_bresp);
        end
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_WIDTH-1:0] addr, output logic [31:0] data);
        int n;
        data = 32'hDEAD_BEEF;
        @(negedge clock);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin @(negedge clock); n++; end
        if (!s_axi_arready) begin
            checks++; failures++;
            $display("FAIL read_arready_timeout addr=%h got=0 want=1", addr);
            s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
            return;
        end
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b00) begin
            failures++;
            $display("FAIL read_rresp addr=%h got rvalid=%b rresp=%b want 1/00", addr, s_axi_rvalid, s_axi_rresp);
        end
        data = s_axi_rdata;
        @(posedge clock); #1;
        s_axi_rready = 1'b0;
    endtask

    // d: +1 forward, -1 reverse, 2 = both phases flip (illegal)
    task automatic move(input int ch, input int d, input int hold);
        @(posedge clock); #1;
        idx[ch] = (idx[ch] + d + 4) % 4;
        enc_a[ch] = (idx[ch] == 1 || idx[ch] == 2);
        enc_b[ch] = (idx[ch] == 2 || idx[ch] == 3);
        last_change = cyc;
        repeat (hold) @(posedge clock);
    endtask

    task automatic expect_reg(input string name, input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] want);
        logic [31:0] got;
        axi_read(addr, got);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s addr=%h got=%h want=%h", name, addr, got, want);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'd0 ||
            s_axi_rdata !== 32'd0 || s_axi_bresp !== 2'd0 || s_axi_rresp !== 2'd0 || trig_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got hs=%b rdata=%h trig=%b want all 0",
                {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}, s_axi_rdata, trig_o);
        end
        reset = 1'b0;
        for (int r = 0; r < 4; r++) expect_reg("reset_ch0_reg", ra(0, r * 4), 32'd0);
        expect_reg("unmapped_7c", 7'h7C, 32'd0);
        axi_write(ra(4, 8), $urandom, 4'hF);
        expect_reg("unmapped_write_ignored", ra(4, 8), 32'd0);
    endtask

    task automatic test_count;
        int d;
        logic last_fwd;
        axi_write(ra(0, 0), 32'h1, 4'hF);
        for (int k = 0; k < 8; k++) begin move(0, 1, $urandom_range(8, 12)); model_pos[0] += 1; end
        expect_reg("pos0_fwd8", ra(0, 4), 32'd8);
        expect_reg("stat0_dir_fwd", ra(0, 12), 32'h1);
        for (int k = 0; k < 3; k++) begin move(0, -1, $urandom_range(8, 12)); model_pos[0] -= 1; end
        expect_reg("pos0_rev3", ra(0, 4), 32'd5);
        expect_reg("stat0_dir_rev", ra(0, 12), 32'h0);
        axi_write(ra(0, 0), 32'h5, 4'hF);
        expect_reg("ctrl0_inv_readback", ra(0, 0), 32'h5);
        last_fwd = 1'b0;
        for (int k = 0; k < 12; k++) begin
            d = ($urandom_range(0, 1) == 1) ? 1 : -1;
            move(0, d, $urandom_range(8, 12));
            model_pos[0] -= d;
            last_fwd = (d < 0);
        end
        expect_reg("pos0_inv_walk", ra(0, 4), 32'(model_pos[0]));
        expect_reg("stat0_inv_dir", ra(0, 12), {31'd0, last_fwd});
        axi_write(ra(0, 0), 32'h1, 4'hF);
    endtask

    task automatic test_divider;
        int exp_cyc [$];
        int dcnt, div, d;
        div = 4; dcnt = 0;
        axi_write(ra(1, 8), 32'd4, 4'hF);
        axi_write(ra(1, 0), 32'h1, 4'hF);
        trig_seen.delete();
        for (int k = 0; k < 10; k++) begin
            move(1, 1, $urandom_range(8, 12));
            model_pos[1] += 1;
            if (dcnt == div - 1) begin dcnt = 0; exp_cyc.push_back(last_change + LAT); end
            else dcnt++;
        end
        checks++;
        if (trig_seen.size() != 2) begin
            failures++;
            $display("FAIL div4_pulse_count got=%0d want=2", trig_seen.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < trig_seen.size(); i++) begin
            checks++;
            if (trig_seen[i] != exp_cyc[i]) begin
                failures++;
                $display("FAIL div4_pulse_cycle[%0d] got=%0d want=%0d", i, trig_seen[i], exp_cyc[i]);
            end
        end
        // random divider and mixed directions, with a disabled stretch in the middle
        div = $urandom_range(1, 5); dcnt = 0;
        axi_write(ra(1, 8), 32'(div), 4'hF);
        trig_seen.delete(); exp_cyc.delete();
        for (int k = 0; k < 16; k++) begin
            if (k == 6) axi_write(ra(1, 0), 32'h0, 4'hF);
            if (k == 10) axi_write(ra(1, 0), 32'h1, 4'hF);
            d = ($urandom_range(0, 3) != 0) ? 1 : -1;
            move(1, d, $urandom_range(8, 12));
            if (k < 6 || k >= 10) begin
                model_pos[1] += d;
                if (d > 0) begin
                    if (dcnt == div - 1) begin dcnt = 0; exp_cyc.push_back(last_change + LAT); end
                    else dcnt++;
                end
            end
        end
        checks++;
        if (trig_seen.size() != exp_cyc.size()) begin
            failures++;
            $display("FAIL div_rand_pulse_count div=%0d got=%0d want=%0d", div, trig_seen.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < trig_seen.size(); i++) begin
            checks++;
            if (trig_seen[i] != exp_cyc[i]) begin
                failures++;
                $display("FAIL div_rand_pulse_cycle[%0d] got=%0d want=%0d", i, trig_seen[i], exp_cyc[i]);
            end
        end
        checks++;
        if (trig_wide != 0) begin
            failures++;
            $display("FAIL trig_width wide_pulses got=%0d want=0", trig_wide);
        end
        expect_reg("pos1_after_div", ra(1, 4), 32'(model_pos[1]));
    endtask

    task automatic test_illegal;
        int d;
        logic [31:0] got;
        logic last_fwd;
        axi_write(ra(2, 0), 32'h1, 4'hF);
        move(2, 2, 12);
        expect_reg("pos2_after_illegal", ra(2, 4), 32'd0);
        expect_reg("stat2_err_set", ra(2, 12), 32'h2);
        axi_write(ra(2, 12), 32'h2, 4'hF);
        expect_reg("stat2_err_cleared", ra(2, 12), 32'h0);
        last_fwd = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d = ($urandom_range(0, 1) == 1) ? 1 : -1;
            move(2, d, $urandom_range(8, 12));
            model_pos[2] += d;
            last_fwd = (d > 0);
        end
        expect_reg("pos2_walk", ra(2, 4), 32'(model_pos[2]));
        expect_reg("stat2_walk", ra(2, 12), {31'd0, last_fwd});
        axi_write(ra(2, 0), 32'h0, 4'hF);
        move(2, 2, 12);
        expect_reg("pos2_disabled_illegal", ra(2, 4), 32'(model_pos[2]));
        axi_read(ra(2, 12), got);
        checks++;
        if (got[1] !== 1'b1) begin
            failures++;
            $display("FAIL stat2_err_when_disabled got=%b want=1", got[1]);
        end
    endtask

    task automatic test_strobes;
        logic [31:0] want, data;
        logic [3:0]  strb;
        want = 32'd0;
        for (int k = 0; k < 4; k++) begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) if (strb[b]) want[8*b +: 8] = data[8*b +: 8];
            axi_write(ra(2, 8), data, strb);
            expect_reg("div2_wstrb", ra(2, 8), want);
        end
    endtask

    task automatic test_filter_clr;
        int w;
        for (int k = 0; k < 2; k++) begin
            w = $urandom_range(1, FILTER_LEN - 1);
            @(posedge clock); #1;
            enc_a[0] = ~enc_a[0];
            repeat (w) @(posedge clock);
            #1;
            enc_a[0] = ~enc_a[0];
            repeat (12) @(posedge clock);
            expect_reg("pos0_glitch_ignored", ra(0, 4), 32'(model_pos[0]));
        end
        axi_write(ra(0, 0), 32'h3, 4'hF);
        model_pos[0] = 0;
        expect_reg("pos0_cleared", ra(0, 4), 32'd0);
        expect_reg("ctrl0_clr_selfclear", ra(0, 0), 32'h1);
        for (int k = 0; k < 2; k++) begin move(0, 1, 10); model_pos[0] += 1; end
        expect_reg("pos0_after_clr", ra(0, 4), 32'd2);
    endtask

    task automatic test_wrap;
        axi_write(ra(3, 0), 32'h1, 4'hF);
        move(3, -1, 12);
        expect_reg("pos3_wrap_neg", ra(3, 4), 32'hFFFF_FFFF);
        move(3, 1, 12);
        expect_reg("pos3_wrap_back", ra(3, 4), 32'h0);
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clock);
        s_axi_awaddr = ra(3, 8); s_axi_wdata = 32'h11; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        s_axi_wdata = 32'h22;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) begin
                failures++;
                $display("FAIL bready_hold cycle=%0d got bvalid=%b awready=%b want 1/0", k, s_axi_bvalid, s_axi_awready);
            end
        end
        s_axi_bready = 1'b1;
        n = 0;
        @(negedge clock);
        while (!s_axi_awready && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (!s_axi_awready) begin
            failures++;
            $display("FAIL second_write_awready got=0 want=1");
        end
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge clock); #1;
        s_axi_bready = 1'b0;
        expect_reg("div3_second_write", ra(3, 8), 32'h22);
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clock);
        s_axi_awaddr = ra(1, 8); s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin @(negedge clock); n++; end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async got aw=%b w=%b b=%b want 0", s_axi_awready, s_axi_wready, s_axi_bvalid);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        expect_reg("ctrl0_after_reset", ra(0, 0), 32'h0);
        expect_reg("div1_after_reset", ra(1, 8), 32'h0);
        expect_reg("pos1_after_reset", ra(1, 4), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin idx[i] = 0; model_pos[i] = 0; end
        fork
            begin
                test_reset;
                test_count;
                test_divider;
                test_illegal;
                test_strobes;
                test_filter_clr;
                test_wrap;
                test_back_to_back;
                test_reset_mid;
            end
            begin
                #2_000_000;
                checks++; failures++;
                $display("FAIL global_timeout got=running want=done");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
